// File: rtl/peltier_regulator_pkg.sv
// Shared definitions for the Peltier temperature regulator: FSM states,
// default timing constants and the width of the MCP3008 result field.
package peltier_regulator_pkg;

    localparam int MCP_RESULT_W    = 10;
    localparam int DEFAULT_PERIOD  = 1000000;
    localparam int DEFAULT_TIMEOUT = 8192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PERIOD,
        ST_REQ,
        ST_WAIT_DATA,
        ST_ACCUM,
        ST_COMPUTE,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/peltier_regulator_p_term.sv
// Proportional term datapath: err * kp, arithmetic right shift, add bias,
// clamp to [0, max_duty]. Combinational in, registered out on load.
module peltier_regulator_p_term #(
    parameter int KP_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic signed [10:0] err,
    input  logic        [7:0]  kp,
    input  logic        [7:0]  bias,
    input  logic        [7:0]  max_duty,
    output logic        [7:0]  duty
);

    logic signed [19:0] err_ext;
    logic signed [19:0] kp_ext;
    logic signed [19:0] product;
    logic signed [19:0] p_val;
    logic signed [19:0] sum;
    logic signed [19:0] max_ext;
    logic        [7:0]  clamped;

    // Signed multiply, floor-rounding shift, bias offset and output clamp
    always_comb begin
        err_ext = {{9{err[10]}}, err};
        kp_ext  = {12'd0, kp};
        product = err_ext * kp_ext;
        p_val   = product >>> KP_SHIFT;
        sum     = p_val + $signed({12'd0, bias});
        max_ext = $signed({12'd0, max_duty});
        if (sum < 0) begin
            clamped = '0;
        end else if (sum > max_ext) begin
            clamped = max_duty;
        end else begin
            clamped = sum[7:0];
        end
    end

    // Result register, loaded once per control update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (load) begin
            duty <= clamped;
        end
    end

endmodule

// File: rtl/peltier_regulator.sv
// Closed-loop Peltier regulator: periodically requests a thermistor
// conversion, snoops the result, averages 2^AVG_LOG2 samples and drives a
// proportional duty. The ADC handshake is observed only, never accepted.
module peltier_regulator
    import peltier_regulator_pkg::*;
#(
    parameter int PERIOD   = DEFAULT_PERIOD,
    parameter int AVG_LOG2 = 2,
    parameter int KP_SHIFT = 4,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [9:0]  setpoint,
    input  logic [7:0]  kp,
    input  logic [7:0]  bias,
    input  logic [7:0]  max_duty,
    input  logic        mcp_busy,
    output logic        mcp_sample,
    input  logic [15:0] mcp_data,
    input  logic        mcp_data_avail,
    output logic [7:0]  duty,
    output logic        duty_valid,
    output logic        fault,
    output logic        busy
);

    localparam int ACC_W = MCP_RESULT_W + AVG_LOG2;
    localparam int PCNT_W = $clog2(PERIOD);
    localparam int TCNT_W = $clog2(TIMEOUT);

    state_t              state, next_state;
    logic [PCNT_W-1:0]   period_cnt;
    logic [TCNT_W-1:0]   timeout_cnt;
    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] sample_cnt;
    logic                avail_prev;
    logic                req_second;
    logic                data_edge;
    logic [9:0]          avg;
    logic signed [10:0]  err;
    logic [7:0]          pterm_duty;
    logic                unused_mcp_hi;

    logic load_period, load_timeout, capture, timeout_hit;
    logic pterm_load, do_update, clear_acc, inc_sample;

    assign data_edge     = mcp_data_avail & ~avail_prev;
    assign avg           = acc[ACC_W-1:AVG_LOG2];
    assign err           = $signed({1'b0, avg}) - $signed({1'b0, setpoint});
    assign mcp_sample    = (state == ST_REQ);
    assign busy          = (state != ST_IDLE);
    assign unused_mcp_hi = ^mcp_data[15:MCP_RESULT_W];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        next_state   = state;
        load_period  = 1'b0;
        load_timeout = 1'b0;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        pterm_load   = 1'b0;
        do_update    = 1'b0;
        clear_acc    = 1'b0;
        inc_sample   = 1'b0;
        if (!enable) begin
            next_state = ST_IDLE;
            clear_acc  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state  = ST_WAIT_PERIOD;
                    load_period = 1'b1;
                end
                ST_WAIT_PERIOD: begin
                    if (period_cnt == '0 && !mcp_busy) begin
                        next_state = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_second) begin
                        next_state   = ST_WAIT_DATA;
                        load_timeout = 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_edge) begin
                        capture    = 1'b1;
                        next_state = ST_ACCUM;
                    end else if (timeout_cnt == '0) begin
                        timeout_hit = 1'b1;
                        next_state  = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    inc_sample = 1'b1;
                    if (sample_cnt == '1) begin
                        next_state = ST_COMPUTE;
                    end else begin
                        next_state  = ST_WAIT_PERIOD;
                        load_period = 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    pterm_load = 1'b1;
                    next_state = ST_UPDATE;
                end
                ST_UPDATE: begin
                    do_update   = 1'b1;
                    clear_acc   = 1'b1;
                    next_state  = ST_WAIT_PERIOD;
                    load_period = 1'b1;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Counters, sample accumulation and the sticky output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt  <= '0;
            timeout_cnt <= '0;
            acc         <= '0;
            sample_cnt  <= '0;
            avail_prev  <= 1'b0;
            req_second  <= 1'b0;
            duty        <= '0;
            duty_valid  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            avail_prev <= mcp_data_avail;
            req_second <= (state == ST_REQ) && !req_second && enable;

            if (load_period) begin
                period_cnt <= PCNT_W'(PERIOD - 1);
            end else if (state == ST_WAIT_PERIOD && period_cnt != '0) begin
                period_cnt <= period_cnt - 1'b1;
            end

            if (load_timeout) begin
                timeout_cnt <= TCNT_W'(TIMEOUT - 1);
            end else if (state == ST_WAIT_DATA && timeout_cnt != '0) begin
                timeout_cnt <= timeout_cnt - 1'b1;
            end

            if (clear_acc) begin
                acc <= '0;
            end else if (capture) begin
                acc <= acc + ACC_W'(mcp_data[MCP_RESULT_W-1:0]);
            end

            if (!enable) begin
                sample_cnt <= '0;
            end else if (inc_sample) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            duty_valid <= 1'b0;
            if (timeout_hit) begin
                duty       <= '0;
                fault      <= 1'b1;
                duty_valid <= 1'b1;
            end else if (do_update) begin
                duty       <= pterm_duty;
                duty_valid <= 1'b1;
            end
        end
    end

    peltier_regulator_p_term #(
        .KP_SHIFT (KP_SHIFT)
    ) u_p_term (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pterm_load),
        .err      (err),
        .kp       (kp),
        .bias     (bias),
        .max_duty (max_duty),
        .duty     (pterm_duty)
    );

endmodule
